// File: rtl/prim_reqack_src_buf_pkg.sv
// Shared types and helpers for the req/ack source-side buffer.
package prim_reqack_src_buf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } src_buf_state_e;

    // Non-power-of-two depths need an explicit wrap instead of natural overflow.
    function automatic logic [31:0] ptr_inc(logic [31:0] ptr, logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/prim_reqack_src_buf_mem.sv
// Depth x Width register storage: one synchronous write port, one asynchronous read port.
module prim_reqack_src_buf_mem #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 2,
    parameter int unsigned PtrW  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we,
    input  logic [PtrW-1:0]  waddr,
    input  logic [Width-1:0] wdata,
    input  logic [PtrW-1:0]  raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prim_reqack_src_buf.sv
// Source-domain FIFO feeding a req/ack CDC synchronizer: holds the head word stable
// under a level request and pops on each single-cycle acknowledge.
module prim_reqack_src_buf
    import prim_reqack_src_buf_pkg::*;
#(
    parameter int unsigned Width  = 1,
    parameter int unsigned Depth  = 2,
    parameter int unsigned DepthW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [Width-1:0]  data_i,
    output logic              src_req_o,
    input  logic              src_ack_i,
    output logic [Width-1:0]  data_o,
    output logic [DepthW-1:0] depth_o,
    output logic              err_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    src_buf_state_e    state_q, state_d;
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [DepthW-1:0] count_q, count_d;
    logic              err_q;
    logic              push, pop;

    // Registered count only, so the producer never sees a path from ack or valid.
    assign ready_o = (count_q < DepthW'(Depth));
    assign push    = valid_i & ready_o;
    assign pop     = (state_q == REQ) & src_ack_i;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + DepthW'(1);
            2'b01:   count_d = count_q - DepthW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        src_req_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = REQ;
            end
            REQ: begin
                src_req_o = 1'b1;
                if (pop && (count_d == '0)) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) wptr_q <= PtrW'(ptr_inc(32'(wptr_q), Depth));
            if (pop)  rptr_q <= PtrW'(ptr_inc(32'(rptr_q), Depth));
            // An ack with no outstanding request means the synchronizer lost sync with us.
            if ((state_q == IDLE) && src_ack_i) err_q <= 1'b1;
        end
    end

    prim_reqack_src_buf_mem #(
        .Width (Width),
        .Depth (Depth),
        .PtrW  (PtrW)
    ) u_mem (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .we    (push),
        .waddr (wptr_q),
        .wdata (data_i),
        .raddr (rptr_q),
        .rdata (data_o)
    );

    assign depth_o = count_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_prim_reqack_src_buf.sv
// Directed bench for prim_reqack_src_buf (Width=8, Depth=3) with a scoreboard on handshakes.
module tb_prim_reqack_src_buf;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 3;
    localparam int unsigned DW = $clog2(D + 1);

    logic          clk_i;
    logic          rst_ni;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  data_i;
    logic          src_req_o;
    logic          src_ack_i;
    logic [W-1:0]  data_o;
    logic [DW-1:0] depth_o;
    logic          err_o;

    int total;
    int bad;
    logic [W-1:0] exp_q [$];

    prim_reqack_src_buf #(
        .Width(W),
        .Depth(D)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .src_req_o(src_req_o),
        .src_ack_i(src_ack_i),
        .data_o   (data_o),
        .depth_o  (depth_o),
        .err_o    (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Push expected to be accepted: the word joins the scoreboard.
    task automatic push(input logic [W-1:0] d);
        valid_i = 1'b1;
        data_i  = d;
        exp_q.push_back(d);
        tick();
        valid_i = 1'b0;
    endtask

    task automatic ack();
        src_ack_i = 1'b1;
        tick();
        src_ack_i = 1'b0;
    endtask

    // A handshake completes at the next posedge whenever req and ack are both high.
    task automatic monitor();
        logic [W-1:0] exp;
        logic [W-1:0] prev_data;
        logic         prev_hold;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && src_req_o && prev_hold) check("req_data_stable", 32'(data_o), 32'(prev_data));
            if (rst_ni && src_req_o && src_ack_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_xfer", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("sb_xfer_data", 32'(data_o), 32'(exp));
                end
            end
            prev_hold = rst_ni && src_req_o && !src_ack_i;
            prev_data = data_o;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_ni    = 1'b0;
        valid_i   = 1'b0;
        src_ack_i = 1'b0;
        data_i    = '0;
        fork
            monitor();
        join_none

        // Reset values
        repeat (2) tick();
        check("rst_req",   32'(src_req_o), 32'd0);
        check("rst_ready", 32'(ready_o),   32'd1);
        check("rst_depth", 32'(depth_o),   32'd0);
        check("rst_data",  32'(data_o),    32'd0);
        check("rst_err",   32'(err_o),     32'd0);
        rst_ni = 1'b1;
        tick();

        // Single word
        push(8'hA5);
        check("single_req_lag",  32'(src_req_o), 32'd0);
        check("single_depth",    32'(depth_o),   32'd1);
        tick();
        check("single_req_up",   32'(src_req_o), 32'd1);
        check("single_data",     32'(data_o),    32'hA5);
        repeat (4) tick();
        ack();
        check("single_req_down", 32'(src_req_o), 32'd0);
        check("single_depth0",   32'(depth_o),   32'd0);

        // Fill to Depth, then an overflow attempt that must be refused
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("fill_ready", 32'(ready_o),   32'd0);
        check("fill_depth", 32'(depth_o),   32'd3);
        check("fill_req",   32'(src_req_o), 32'd1);
        valid_i = 1'b1;
        data_i  = 8'h99;
        tick();
        valid_i = 1'b0;
        check("full_depth", 32'(depth_o), 32'd3);
        check("full_data",  32'(data_o),  32'h01);

        // Back-to-back drain, one ack every 4 cycles
        for (int i = 0; i < 3; i++) begin
            repeat (3) begin
                tick();
                check("drain_req_held", 32'(src_req_o), 32'd1);
            end
            ack();
        end
        check("drain_req_down", 32'(src_req_o), 32'd0);
        check("drain_depth",    32'(depth_o),   32'd0);
        check("drain_ready",    32'(ready_o),   32'd1);

        // Simultaneous push and pop with one entry
        push(8'h11);
        tick();
        check("simul_pre_req", 32'(src_req_o), 32'd1);
        valid_i   = 1'b1;
        data_i    = 8'h7E;
        src_ack_i = 1'b1;
        exp_q.push_back(8'h7E);
        tick();
        valid_i   = 1'b0;
        src_ack_i = 1'b0;
        check("simul_depth", 32'(depth_o),   32'd1);
        check("simul_req",   32'(src_req_o), 32'd1);
        check("simul_data",  32'(data_o),    32'h7E);
        tick();
        ack();
        check("simul_idle", 32'(src_req_o), 32'd0);

        // Spurious ack in IDLE; head slot is mem[0] which last held 0x03
        check("spur_pre_data", 32'(data_o), 32'h03);
        ack();
        check("spur_err",   32'(err_o),     32'd1);
        check("spur_depth", 32'(depth_o),   32'd0);
        check("spur_data",  32'(data_o),    32'h03);
        check("spur_req",   32'(src_req_o), 32'd0);
        repeat (3) tick();
        check("spur_sticky", 32'(err_o), 32'd1);

        // Reset mid-operation
        push(8'h21);
        push(8'h22);
        check("mid_req",   32'(src_req_o), 32'd1);
        check("mid_depth", 32'(depth_o),   32'd2);
        #2;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        check("arst_req",   32'(src_req_o), 32'd0);
        check("arst_depth", 32'(depth_o),   32'd0);
        check("arst_err",   32'(err_o),     32'd0);
        check("arst_ready", 32'(ready_o),   32'd1);
        tick();
        rst_ni = 1'b1;
        tick();
        push(8'h3C);
        tick();
        check("post_rst_req",  32'(src_req_o), 32'd1);
        check("post_rst_data", 32'(data_o),    32'h3C);
        ack();
        check("post_rst_depth", 32'(depth_o), 32'd0);

        repeat (2) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prim_reqack_src_buf.md
Name: prim_reqack_src_buf

Overview:
- Source-domain buffer that sits directly upstream of the req/ack CDC data synchronizer.
- Accepts a valid/ready stream and queues up to Depth words.
- Presents the head word on data_o, held stable, together with a level request src_req_o until the synchronizer returns a src_ack_i pulse, then pops.
- Lets a producer stream data without tracking the slow CDC handshake itself.

Parameters:
- Width, 1, data word width in bits (>=1).
- Depth, 2, number of buffered entries (>=1; need not be a power of two).
- DepthW, $clog2(Depth+1), derived, width of the occupancy count; not to be overridden.

Ports:
- clk_i  input  1  source-domain clock.
- rst_ni  input  1  reset.
- valid_i  input  1  producer has a word on data_i.
- ready_o  output  1  buffer can accept a word this cycle.
- data_i  input  Width  producer data.
- src_req_o  output  1  request to the synchronizer's src_req_i.
- src_ack_i  input  1  single-cycle acknowledge from the synchronizer's src_ack_o.
- data_o  output  Width  head word, to the synchronizer's data_i.
- depth_o  output  DepthW  current occupancy.
- err_o  output  1  sticky protocol-error flag.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: src_req_o=0, ready_o=1, depth_o=0, data_o=0, err_o=0, state IDLE, read and write pointers 0. Storage contents are also reset to 0.
- Push: occurs when valid_i & ready_o. ready_o = (count < Depth), a pure function of registered count. There is no combinational path from src_ack_i or valid_i to ready_o.
- Full with simultaneous ack: no push that cycle; the freed slot is visible the next cycle.
- Pointers: wrap at Depth-1 back to 0, which is explicit for non-power-of-two Depth.
- FSM states: IDLE and REQ.
  - IDLE: src_req_o=0. Moves to REQ when count>0, evaluated on registered count. A push into an empty buffer raises src_req_o 1 cycle after the push edge.
  - REQ: src_req_o=1. data_o = mem[rptr] and must not change while in REQ.
  - On src_ack_i in REQ: pop (rptr++, count--).
  - After a pop, if count (after pop and any same-cycle push) > 0, stay in REQ. src_req_o stays high and data_o updates to the next head the following cycle (back-to-back transfers).
  - After a pop that leaves the buffer empty, go to IDLE.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push on the same edge as the last pop: stay in REQ with the new word at the head.
- Spurious ack (src_ack_i=1 while in IDLE): no pop, err_o set. err_o clears only on reset.
- Data stability: a write never targets the rptr slot while that slot is outstanding. This is guaranteed because a push is only accepted when count<Depth.
- Reset mid-transfer: buffer is flushed and src_req_o drops asynchronously. The system must reset the synchronizer's source side in the same event.
- depth_o equals count, registered.

Decomposition:
- Package prim_reqack_src_buf_pkg holds:
  - the state enum src_buf_state_e (IDLE, REQ), 1-bit encoded;
  - the helper function for pointer increment with wrap.
- One sub-module, prim_reqack_src_buf_mem: Depth x Width register storage with a write port and an asynchronous read port at rptr.
- FSM, pointers and count live in the top module.

Test Plan:
- Single word: after reset, push data_i=0xA5 (Width=8) → src_req_o rises 1 cycle later with data_o=0xA5 held. Pulse src_ack_i 5 cycles later → src_req_o=0 next cycle, depth_o=0.
- Fill: Depth=3, push 0x01,0x02,0x03 with no ack → ready_o=0 after the third push, depth_o=3. A further valid_i is not accepted and data_o stays 0x01.
- Back-to-back drain: from full, ack every 4 cycles → src_req_o stays 1 throughout, data_o sequence 0x01→0x02→0x03, then src_req_o=0.
- Simultaneous push/pop: with 1 entry, push 0x7E on the same cycle as ack → depth_o stays 1, state REQ, data_o=0x7E next cycle.
- Spurious ack: src_ack_i=1 while IDLE → err_o=1 and remains 1. depth_o unchanged, no pointer movement.
- Reset mid-operation: with 2 entries queued and src_req_o=1, assert rst_ni low mid-cycle → src_req_o=0 and depth_o=0 immediately. After release, a new push 0x3C appears at data_o.
